rf_wport_arbiter: RTL and testbench

RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

---
 rtl/rf_wport_arbiter_pkg.sv | 25 ++
 rtl/rf_wq_fifo.sv | 75 +++++++
 rtl/rf_wport_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, constants and types for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int BUS_W   = 38;  // {we, waddr[4:0], wdata[31:0]}
  localparam int RADDR_W = 5;
  localparam int DATA_W  = 32;
  localparam int BUS_WE_BIT = 37;

  // Register $0 is hard-wired to zero: writes to it are dropped.
  localparam logic [RADDR_W-1:0] ZERO_REG = '0;

  // One buffered secondary write.
  typedef struct packed {
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
  } wq_entry_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2
  } wsrc_e;

endpackage

// File: rtl/rf_wq_fifo.sv
// Circular buffer of secondary register writes. Exposes the head entry for the
// write port and every slot's address/valid bit for decode-stage hazard checks.
module rf_wq_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [RADDR_W-1:0]         push_waddr,
  input  logic [DATA_W-1:0]          push_wdata,
  input  logic                       pop,
  output logic [RADDR_W-1:0]         head_waddr,
  output logic [DATA_W-1:0]          head_wdata,
  output logic [CNT_W-1:0]           count,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH*RADDR_W-1:0]   entry_waddr
);

  wq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data storage write at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; validity comes from count/head alone.
    if (push) mem[tail_q] <= '{waddr: push_waddr, wdata: push_wdata};
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    off         = '0;
    entry_valid = '0;
    entry_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      entry_valid[i] = ({1'b0, off} < count_q);
      entry_waddr[i*RADDR_W +: RADDR_W] = mem[i].waddr;
    end
  end

  assign head_waddr = mem[head_q].waddr;
  assign head_wdata = mem[head_q].wdata;
  assign count      = count_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between the write-back stage and a
// buffered multi-cycle unit. The pipeline normally wins; a starvation counter
// forces a one-cycle write-back hold so buffered results eventually drain.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BUS_W-1:0]   ws_to_rf_bus,
  output logic               ws_hold,
  input  logic               mc_valid,
  output logic               mc_ready,
  input  logic [RADDR_W-1:0] mc_waddr,
  input  logic [DATA_W-1:0]  mc_wdata,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  output logic               rs_pend,
  output logic               rt_pend,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic                     ws_we;
  logic [RADDR_W-1:0]       ws_waddr;
  logic [DATA_W-1:0]        ws_wdata;
  logic                     push, pop;
  logic                     fifo_nonempty;
  wsrc_e                    src;
  logic [RADDR_W-1:0]       head_waddr;
  logic [DATA_W-1:0]        head_wdata;
  logic [CNT_W-1:0]         count;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH*RADDR_W-1:0] entry_waddr;
  logic [ST_W-1:0]          starve_q, starve_d;
  logic                     ws_hold_q, ws_hold_d;

  assign ws_we    = ws_to_rf_bus[BUS_WE_BIT];
  assign ws_waddr = ws_to_rf_bus[DATA_W +: RADDR_W];
  assign ws_wdata = ws_to_rf_bus[DATA_W-1:0];

  assign fifo_nonempty = (count != '0);
  // Full means not ready even when the head pops this cycle: no pass-through.
  assign mc_ready = (count < CNT_W'(DEPTH));
  // Writes to $0 are acknowledged but never stored.
  assign push     = mc_valid && mc_ready && (mc_waddr != ZERO_REG);
  assign pop      = (src == SRC_FIFO);
  assign ws_hold  = ws_hold_q;

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_waddr  (mc_waddr),
    .push_wdata  (mc_wdata),
    .pop         (pop),
    .head_waddr  (head_waddr),
    .head_wdata  (head_wdata),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_waddr (entry_waddr)
  );

  // Port grant and write-port mux; pipeline bus is the idle default.
  always_comb begin
    src      = SRC_NONE;
    rf_we    = 1'b0;
    rf_waddr = ws_waddr;
    rf_wdata = ws_wdata;
    if (ws_we && !ws_hold_q) begin
      src   = SRC_PIPE;
      // A $0 write still occupies the port; it just never reaches the file.
      rf_we = (ws_waddr != ZERO_REG);
    end else if (fifo_nonempty) begin
      src      = SRC_FIFO;
      rf_we    = 1'b1;
      rf_waddr = head_waddr;
      rf_wdata = head_wdata;
    end
  end

  // Starvation tracking: count pipeline wins while entries wait, saturating.
  always_comb begin
    starve_d = starve_q;
    if (pop || !fifo_nonempty) begin
      starve_d = '0;
    end else if (src == SRC_PIPE && starve_q != ST_W'(STARVE_MAX)) begin
      starve_d = starve_q + ST_W'(1);
    end
    // Hitting the threshold holds write-back next cycle; that cycle pops and
    // clears the counter, so the hold can never last two cycles.
    ws_hold_d = (starve_d == ST_W'(STARVE_MAX)) && fifo_nonempty;
  end

  // Starvation state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q  <= '0;
      ws_hold_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      ws_hold_q <= ws_hold_d;
    end
  end

  // Decode hazard: a source register is pending while any live entry targets it.
  always_comb begin
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_waddr[i*RADDR_W +: RADDR_W] == rs_addr && rs_addr != ZERO_REG)
        rs_pend = 1'b1;
      if (entry_valid[i] && entry_waddr[i*RADDR_W +: RADDR_W] == rt_addr && rt_addr != ZERO_REG)
        rt_pend = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4). Inputs change
// just after the falling edge; outputs are sampled 1 ns later.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] ws_to_rf_bus;
  logic        ws_hold;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_waddr;
  logic [31:0] mc_wdata;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_pend, rt_pend;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ws_to_rf_bus (ws_to_rf_bus),
    .ws_hold      (ws_hold),
    .mc_valid     (mc_valid),
    .mc_ready     (mc_ready),
    .mc_waddr     (mc_waddr),
    .mc_wdata     (mc_wdata),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_pend      (rs_pend),
    .rt_pend      (rt_pend),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and let combinational outputs settle.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    ws_to_rf_bus = {we, wa, wd};
    mc_valid     = mv;
    mc_waddr     = ma;
    mc_wdata     = md;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 5'd13, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    checks++; if (ws_hold !== 1'b0) begin failures++; $display("FAIL reset_hold: got %0b want 0", ws_hold); end
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", mc_ready); end
    checks++; if (rs_pend !== 1'b0 || rt_pend !== 1'b0) begin failures++; $display("FAIL reset_pend: got %0b%0b want 00", rs_pend, rt_pend); end
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd13 || rf_wdata !== 32'h1234) begin
      failures++; $display("FAIL reset_idle_bus: got we=%0b a=%0d d=%h want 0/13/1234", rf_we, rf_waddr, rf_wdata); end
    drive(1'b1, 5'd12, 32'h00C0_FFEE, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h00C0_FFEE) begin
      failures++; $display("FAIL reset_pipe_we: got we=%0b a=%0d d=%h want 1/12/c0ffee", rf_we, rf_waddr, rf_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_idle_mc();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    checks++; if (rf_we !== 1'b0 || mc_ready !== 1'b1) begin
      failures++; $display("FAIL idle_mc_c0: got we=%0b rdy=%0b want 0/1", rf_we, mc_ready); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11 || mc_ready !== 1'b1) begin
      failures++; $display("FAIL idle_mc_c1: got we=%0b a=%0d d=%h rdy=%0b want 1/5/11/1", rf_we, rf_waddr, rf_wdata, mc_ready); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL idle_mc_c2: got we=%0b want 0", rf_we); end
  endtask

  task automatic test_starve();
    logic        exp_hold, exp_rdy;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 5'd1, 32'hA0 + c, (c < 2), (c == 0) ? 5'd7 : 5'd8, (c == 0) ? 32'h77 : 32'h88);
      exp_hold = (c == 5) || (c == 10);
      exp_rdy  = !(c >= 2 && c <= 5);
      exp_a    = (c == 5) ? 5'd7 : (c == 10) ? 5'd8 : 5'd1;
      exp_d    = (c == 5) ? 32'h77 : (c == 10) ? 32'h88 : 32'hA0 + c;
      checks++; if (ws_hold !== exp_hold || mc_ready !== exp_rdy || rf_we !== 1'b1 ||
                    rf_waddr !== exp_a || rf_wdata !== exp_d) begin
        failures++;
        $display("FAIL starve_c%0d: got hold=%0b rdy=%0b we=%0b a=%0d d=%h want %0b/%0b/1/%0d/%h",
                 c, ws_hold, mc_ready, rf_we, rf_waddr, rf_wdata, exp_hold, exp_rdy, exp_a, exp_d);
      end
    end
  endtask

  task automatic test_pend();
    rs_addr = 5'd9; rt_addr = 5'd0;
    drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd9, 32'h99);
    checks++; if (rs_pend !== 1'b0) begin failures++; $display("FAIL pend_c0: got rs=%0b want 0", rs_pend); end
    drive(1'b1, 5'd2, 32'h201, 1'b0, 5'd0, 32'd0);
    checks++; if (rs_pend !== 1'b1 || rt_pend !== 1'b0 || rf_waddr !== 5'd2) begin
      failures++; $display("FAIL pend_c1: got rs=%0b rt=%0b a=%0d want 1/0/2", rs_pend, rt_pend, rf_waddr); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 || rs_pend !== 1'b1) begin
      failures++; $display("FAIL pend_c2: got we=%0b a=%0d d=%h rs=%0b want 1/9/99/1", rf_we, rf_waddr, rf_wdata, rs_pend); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rs_pend !== 1'b0 || rf_we !== 1'b0) begin
      failures++; $display("FAIL pend_c3: got rs=%0b we=%0b want 0/0", rs_pend, rf_we); end
    rs_addr = 5'd0;
  endtask

  task automatic test_zero_pipe();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b0 || ws_hold !== 1'b0) begin
        failures++; $display("FAIL zero_pipe_c%0d: got we=%0b hold=%0b want 0/0", c, rf_we, ws_hold); end
    end
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    checks++; if (ws_hold !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin
      failures++; $display("FAIL zero_pipe_hold: got hold=%0b we=%0b a=%0d d=%h want 1/1/3/33", ws_hold, rf_we, rf_waddr, rf_wdata); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (ws_hold !== 1'b0 || rf_we !== 1'b0) begin
      failures++; $display("FAIL zero_pipe_after: got hold=%0b we=%0b want 0/0", ws_hold, rf_we); end
  endtask

  task automatic test_mc_zero();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    checks++; if (mc_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++; $display("FAIL mc_zero_c0: got rdy=%0b we=%0b want 1/0", mc_ready, rf_we); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mc_zero_nowrite: got we=%0b want 0", rf_we); end
    // With the pipeline busy, a discarded $0 must leave room for two real entries.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd0, 32'h55);
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd4, 32'h44);
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL mc_zero_rdy1: got %0b want 1", mc_ready); end
    drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd6, 32'h66);
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL mc_zero_rdy2: got %0b want 1", mc_ready); end
    drive(1'b1, 5'd1, 32'h103, 1'b0, 5'd0, 32'd0);
    checks++; if (mc_ready !== 1'b0) begin failures++; $display("FAIL mc_zero_full: got %0b want 0", mc_ready); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44 || ws_hold !== 1'b0) begin
      failures++; $display("FAIL mc_zero_drain4: got we=%0b a=%0d d=%h hold=%0b want 1/4/44/0", rf_we, rf_waddr, rf_wdata, ws_hold); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
      failures++; $display("FAIL mc_zero_drain6: got we=%0b a=%0d d=%h want 1/6/66", rf_we, rf_waddr, rf_wdata); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mc_zero_empty: got we=%0b want 0", rf_we); end
  endtask

  task automatic test_reset_mid();
    rs_addr = 5'd10; rt_addr = 5'd11;
    drive(1'b1, 5'd1, 32'h300, 1'b1, 5'd10, 32'hAA);
    drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd11, 32'hBB);
    checks++; if (rs_pend !== 1'b1) begin failures++; $display("FAIL rmid_pend_before: got %0b want 1", rs_pend); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    checks++; if (mc_ready !== 1'b1 || rf_we !== 1'b0 || rs_pend !== 1'b0 || rt_pend !== 1'b0 || ws_hold !== 1'b0) begin
      failures++; $display("FAIL rmid_after: got rdy=%0b we=%0b rs=%0b rt=%0b hold=%0b want 1/0/0/0/0",
                           mc_ready, rf_we, rs_pend, rt_pend, ws_hold); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rmid_nowrite_c%0d: got we=%0b want 0", c, rf_we); end
    end
  endtask

  initial begin
    reset        = 1'b1;
    ws_to_rf_bus = '0;
    mc_valid     = 1'b0;
    mc_waddr     = '0;
    mc_wdata     = '0;
    rs_addr      = '0;
    rt_addr      = '0;
    test_reset();
    test_idle_mc();
    test_starve();
    test_pend();
    test_zero_pipe();
    test_mc_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
